mpu_frame_asm: RTL and testbench

- Sits between the bit-banged I2C master and the attitude/PID controller.
- On a request, issues one burst-read pulse to the I2C master and collects the 14-byte MPU6050 register burst (0x3B..0x48) from its byte stream.
- Assembles the bytes into seven signed 16-bit words and presents them as one frame through a valid/ready handshake.
- Detects short or stalled bursts with a watchdog.

---
 rtl/mpu_frame_asm.sv | 160 ++++++++++++++++
 tb/tb_mpu_frame_asm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_frame_asm.sv
// mpu_frame_asm: requests one MPU6050 burst read from the I2C master, collects
// the 14-byte register burst, and presents seven signed 16-bit words as a frame
// over a valid/ready handshake. A watchdog and a busy-drop check catch short or
// stalled bursts.
`timescale 1ns/1ps
module mpu_frame_asm #(
    parameter int unsigned FRAME_BYTES = 14,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             iic_busy,
    input  logic             iic_avalid,
    input  logic [7:0]       iic_data,
    output logic             iic_transfer,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [15:0]      accel_x,
    output logic [15:0]      accel_y,
    output logic [15:0]      accel_z,
    output logic [15:0]      temp_raw,
    output logic [15:0]      gyro_x,
    output logic [15:0]      gyro_y,
    output logic [15:0]      gyro_z,
    output logic             timeout_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned IDX_W   = $clog2(FRAME_BYTES);
    localparam int unsigned WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned N_WORDS = FRAME_BYTES / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_COLLECT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [WD_W-1:0]    r_wdog;
    logic               r_busy_d;
    logic               r_busy_fell;
    logic [7:0]         r_shadow [FRAME_BYTES-1];
    logic [7:0]         w_bytes  [FRAME_BYTES];
    logic [15:0]        r_words  [N_WORDS];
    logic               r_iic_transfer;
    logic               r_frame_valid;
    logic               r_timeout_err;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic               w_in_burst;
    logic               w_is_last_idx;
    logic               w_last;
    logic               w_expire;

    assign w_in_burst    = (r_state == S_REQ) || (r_state == S_COLLECT);
    assign w_is_last_idx = (r_idx == IDX_W'(FRAME_BYTES - 1));
    assign w_last        = (r_state == S_COLLECT) && iic_avalid && w_is_last_idx;
    // Expiry cycle is the last cycle a strobe still counts; ERR follows it.
    assign w_expire      = (r_wdog == WD_W'(TIMEOUT_CYC - 1));

    // Frame view: shadow bytes plus the final byte taken straight off the bus.
    always_comb begin
        for (int i = 0; i < int'(FRAME_BYTES) - 1; i++) begin
            w_bytes[i] = r_shadow[i];
        end
        w_bytes[FRAME_BYTES-1] = iic_data;
    end

    // Next-state logic; a completing last byte wins over timeout or busy drop.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (start && !iic_busy) w_next = S_REQ;
            S_REQ:     w_next = w_expire ? S_ERR : S_COLLECT;
            S_COLLECT: begin
                if (w_last)                       w_next = S_HOLD;
                else if (w_expire || r_busy_fell) w_next = S_ERR;
            end
            S_HOLD:    if (frame_ready) w_next = S_IDLE;
            S_ERR:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Burst bookkeeping: byte index, watchdog and busy falling-edge flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_wdog      <= '0;
            r_busy_d    <= 1'b0;
            r_busy_fell <= 1'b0;
        end else begin
            r_busy_d    <= iic_busy;
            r_busy_fell <= w_in_burst && r_busy_d && !iic_busy;
            if (r_state == S_IDLE) begin
                r_idx  <= '0;
                r_wdog <= '0;
            end else if (w_in_burst) begin
                r_wdog <= r_wdog + WD_W'(1);
                if (r_state == S_COLLECT && iic_avalid) r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Shadow capture of all bytes except the last, which loads directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FRAME_BYTES) - 1; i++) r_shadow[i] <= '0;
        end else if (r_state == S_COLLECT && iic_avalid && !w_is_last_idx) begin
            r_shadow[r_idx] <= iic_data;
        end
    end

    // Output registers: single simultaneous word load, flags and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N_WORDS); k++) r_words[k] <= '0;
            r_iic_transfer <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_frame_cnt    <= '0;
        end else begin
            r_iic_transfer <= (w_next == S_REQ);
            r_frame_valid  <= (w_next == S_HOLD);
            if (r_state == S_IDLE && w_next == S_REQ) r_timeout_err <= 1'b0;
            else if (w_next == S_ERR)                 r_timeout_err <= 1'b1;
            if (w_last) begin
                for (int k = 0; k < int'(N_WORDS); k++) begin
                    r_words[k] <= {w_bytes[2*k], w_bytes[2*k+1]};
                end
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign iic_transfer = r_iic_transfer;
    assign frame_valid  = r_frame_valid;
    assign timeout_err  = r_timeout_err;
    assign frame_cnt    = r_frame_cnt;
    assign accel_x      = r_words[0];
    assign accel_y      = r_words[1];
    assign accel_z      = r_words[2];
    assign temp_raw     = r_words[3];
    assign gyro_x       = r_words[4];
    assign gyro_y       = r_words[5];
    assign gyro_z       = r_words[6];

endmodule

// File: tb/tb_mpu_frame_asm.sv
// Bench for mpu_frame_asm: transaction-level model of expected outputs,
// compared against the DUT every cycle, plus literal pins on key values.
`timescale 1ns/1ps
module tb_mpu_frame_asm;

    localparam int unsigned T = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        iic_busy = 1'b0;
    logic        iic_avalid = 1'b0;
    logic [7:0]  iic_data = 8'h00;
    logic        frame_ready = 1'b0;
    logic        iic_transfer, frame_valid, timeout_err;
    logic [15:0] accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z;
    logic [7:0]  frame_cnt;

    mpu_frame_asm #(.FRAME_BYTES(14), .TIMEOUT_CYC(T), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iic_busy(iic_busy),
        .iic_avalid(iic_avalid), .iic_data(iic_data), .iic_transfer(iic_transfer),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp_raw(temp_raw),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] burst_t [14];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_xfer = 0;
    logic [15:0] m_w [7];
    logic [7:0]  m_cnt;
    logic        m_err, m_valid, m_xfer;
    string       wname [7] = '{"accel_x", "accel_y", "accel_z", "temp_raw",
                               "gyro_x", "gyro_y", "gyro_z"};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp
        logic [15:0] act [7];
        act = '{accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z};
        for (int k = 0; k < 7; k++) chk(wname[k], 32'(act[k]), 32'(m_w[k]));
        chk("frame_valid", 32'(frame_valid), 32'(m_valid));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("iic_transfer", 32'(iic_transfer), 32'(m_xfer));
        if (iic_transfer === 1'b1) n_xfer++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int k = 0; k < 7; k++) m_w[k] = 16'h0000;
        m_cnt = 8'h00; m_err = 1'b0; m_valid = 1'b0; m_xfer = 1'b0;
    endtask

    // A completed burst: big-endian word pairs, counter advances, frame valid.
    task automatic model_frame(input burst_t b);
        for (int k = 0; k < 7; k++) m_w[k] = {b[2*k], b[2*k+1]};
        m_cnt   = m_cnt + 8'd1;
        m_valid = 1'b1;
    endtask

    task automatic request();
        start = 1'b1;
        step();
        m_xfer = 1'b1; m_err = 1'b0;
        start = 1'b0; iic_busy = 1'b1;
    endtask

    task automatic send_frame(input burst_t b, input int gmin, input int gmax,
                              input int hold, input bit inject, input int holdoff);
        iic_busy = (holdoff > 0);
        start = 1'b1;
        repeat (holdoff) step();
        iic_busy = 1'b0;
        request();
        step();
        m_xfer = 1'b0;
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(gmax, gmin)) step();
            iic_avalid = 1'b1; iic_data = b[i];
            step();
            iic_avalid = 1'b0; iic_data = 8'($urandom);
        end
        model_frame(b);
        chk("valid_latency", 32'(frame_valid), 32'd1);
        iic_busy = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (inject) begin
                iic_avalid = (h == 0) || ($urandom_range(1, 0) == 1);
                iic_data   = 8'($urandom);
                start      = (h == 0) || ($urandom_range(3, 0) == 0);
            end
            step();
        end
        iic_avalid = 1'b0; start = 1'b0; frame_ready = 1'b1;
        step();
        m_valid = 1'b0; frame_ready = 1'b0;
    endtask

    task automatic short_burst(input int n);
        request();
        step();
        m_xfer = 1'b0;
        for (int i = 0; i < n; i++) begin
            iic_avalid = 1'b1; iic_data = 8'($urandom);
            step();
            iic_avalid = 1'b0;
        end
        iic_busy = 1'b0;
        step();
        step();
        m_err = 1'b1;
        step();
    endtask

    task automatic watchdog_case(input int n_early, input int last_at,
                                 input bit send_last, input int exp_lat);
        burst_t b;
        int     c;
        int     lat;
        bit     done;
        lat = -1; done = 1'b0;
        for (int j = 0; j < 14; j++) b[j] = 8'($urandom);
        request();
        c = 0;
        while (c < last_at) begin
            if (c >= 1 && c <= n_early) begin
                iic_avalid = 1'b1; iic_data = b[c-1];
            end
            step();
            iic_avalid = 1'b0; c++;
            if (c == 1) m_xfer = 1'b0;
            if (c == int'(T)) m_err = 1'b1;
            if (timeout_err === 1'b1 && lat < 0) lat = c;
        end
        if (send_last) begin
            iic_avalid = 1'b1; iic_data = b[13];
        end
        step();
        iic_avalid = 1'b0; c++;
        if (send_last && last_at < int'(T)) begin
            model_frame(b); done = 1'b1;
        end else if (c == int'(T)) begin
            m_err = 1'b1;
        end
        if (timeout_err === 1'b1 && lat < 0) lat = c;
        chk("wd_latency", 32'(lat), 32'(exp_lat));
        iic_busy = 1'b0;
        if (done) begin
            frame_ready = 1'b1;
            step();
            m_valid = 1'b0; frame_ready = 1'b0;
        end
        repeat (2) step();
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL global_timeout: got stuck expected finish at %0t", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        burst_t b;
        model_zero();
        repeat (3) step();
        chk("reset_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_accel_x", 32'(accel_x), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Ramp bytes 0x01..0x0E, strobes 3 cycles apart, long hold with injections.
        for (int j = 0; j < 14; j++) b[j] = 8'(j + 1);
        send_frame(b, 2, 2, 50, 1'b1, 0);
        chk("lit_accel_x", 32'(accel_x), 32'h0102);
        chk("lit_gyro_z", 32'(gyro_z), 32'h0D0E);
        chk("lit_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("lit_xfer_pulses", 32'(n_xfer), 32'd1);
        repeat (2) step();

        // Short burst followed by busy drop: error, words retained.
        short_burst(10);
        chk("lit_short_err", 32'(timeout_err), 32'd1);
        chk("lit_short_keep", 32'(accel_x), 32'h0102);
        chk("lit_short_cnt", 32'(frame_cnt), 32'd1);
        for (int j = 0; j < 14; j++) b[j] = 8'($urandom);
        send_frame(b, 0, 2, 2, 1'b0, 2);
        chk("lit_err_cleared", 32'(timeout_err), 32'd0);

        // Watchdog: no strobes, last byte at expiry cycle, last byte one late.
        watchdog_case(0, int'(T) + 1, 1'b0, int'(T));
        watchdog_case(13, int'(T) - 1, 1'b1, -1);
        chk("lit_edge_noerr", 32'(timeout_err), 32'd0);
        watchdog_case(13, int'(T), 1'b1, int'(T));

        // Reset mid-burst, then stray bytes after release.
        request();
        step();
        m_xfer = 1'b0;
        for (int i = 0; i < 7; i++) begin
            iic_avalid = 1'b1; iic_data = 8'($urandom);
            step();
            iic_avalid = 1'b0;
        end
        rst_n = 1'b0;
        model_zero();
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            iic_avalid = 1'b1; iic_data = 8'($urandom);
            step();
            iic_avalid = 1'b0;
        end
        iic_busy = 1'b0;
        repeat (3) step();
        chk("lit_rst_cnt", 32'(frame_cnt), 32'd0);
        chk("lit_rst_valid", 32'(frame_valid), 32'd0);
        chk("lit_rst_gyro_z", 32'(gyro_z), 32'd0);

        // 256 random frames: counter wraps; final frame carries accel_z = -200.
        for (int f = 0; f < 256; f++) begin
            for (int j = 0; j < 14; j++) b[j] = 8'($urandom);
            if (f == 255) begin
                b[4] = 8'hFF; b[5] = 8'h38;
            end
            send_frame(b, 0, 3, $urandom_range(4, 0), 1'($urandom_range(1, 0)),
                       $urandom_range(2, 0));
        end
        chk("lit_wrap_cnt", 32'(frame_cnt), 32'd0);
        chk("lit_accel_z_neg200", 32'($signed(accel_z)), 32'hFFFF_FF38);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
